// File: rtl/pbit_sample_stats.sv
// Statistics stage for p-bit networks: after an optional settle period, counts
// ones per bit over a programmable window and reports counts plus a majority vote.
module pbit_sample_stats #(
  parameter int N_BITS    = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [7:0]                  settle,
  input  logic [CNT_WIDTH-1:0]        window,
  input  logic [N_BITS-1:0]           p_bits,
  output logic                        busy,
  output logic                        done,
  output logic                        results_valid,
  output logic [N_BITS*CNT_WIDTH-1:0] counts,
  output logic [N_BITS-1:0]           majority
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_next;
  logic                 start_ok;
  logic                 last_sample;
  logic [7:0]           settle_cnt;
  logic [CNT_WIDTH-1:0] window_lat;
  logic [CNT_WIDTH-1:0] sample_cnt;
  logic [CNT_WIDTH-1:0] count     [N_BITS];
  logic [CNT_WIDTH-1:0] count_inc [N_BITS];

  always_comb begin
    state_next  = state;
    start_ok    = 1'b0;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (settle != 8'd0)
            state_next = SETTLE;
          else if (window != CNT_ZERO)
            state_next = ACCUM;
          else
            state_next = DONE;
        end
      end
      SETTLE: begin
        if (abort)
          state_next = IDLE;
        else if (settle_cnt == 8'd1)
          state_next = (window_lat != CNT_ZERO) ? ACCUM : DONE;
      end
      ACCUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (sample_cnt == window_lat - CNT_ONE) begin
          last_sample = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_BITS; i++)
      count_inc[i] = count[i] + {{(CNT_WIDTH-1){1'b0}}, p_bits[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Counters, latched parameters and results; abort leaves partial counts in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt    <= 8'd0;
      window_lat    <= CNT_ZERO;
      sample_cnt    <= CNT_ZERO;
      majority      <= {N_BITS{1'b0}};
      results_valid <= 1'b0;
      for (int i = 0; i < N_BITS; i++)
        count[i] <= CNT_ZERO;
    end else if (start_ok) begin
      settle_cnt    <= settle;
      window_lat    <= window;
      sample_cnt    <= CNT_ZERO;
      majority      <= {N_BITS{1'b0}};
      results_valid <= (state_next == DONE);
      for (int i = 0; i < N_BITS; i++)
        count[i] <= CNT_ZERO;
    end else if (abort && (state != IDLE)) begin
      results_valid <= 1'b0;
    end else begin
      if (state == SETTLE)
        settle_cnt <= settle_cnt - 8'd1;
      if (state == ACCUM) begin
        sample_cnt <= sample_cnt + CNT_ONE;
        for (int i = 0; i < N_BITS; i++)
          count[i] <= count_inc[i];
      end
      // Majority uses the count including the final sample, so it lands with done.
      if (last_sample) begin
        for (int i = 0; i < N_BITS; i++)
          majority[i] <= ({count_inc[i], 1'b0} > {1'b0, window_lat});
      end
      if (state_next == DONE)
        results_valid <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_BITS; g++) begin : g_counts
    assign counts[g*CNT_WIDTH +: CNT_WIDTH] = count[g];
  end

endmodule

// File: tb/tb_pbit_sample_stats.sv
// Directed bench for pbit_sample_stats: per-run expectations go into a scoreboard
// queue when a measurement starts and are checked when done pulses.
module tb_pbit_sample_stats;

  localparam int NB = 5;
  localparam int CW = 16;
  localparam int STIM_LEN = 10200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [7:0]        settle;
  logic [CW-1:0]     window;
  logic [NB-1:0]     p_bits;
  logic              busy;
  logic              done;
  logic              results_valid;
  logic [NB*CW-1:0]  counts;
  logic [NB-1:0]     majority;

  typedef struct {
    int        cnt [NB];
    logic [4:0] maj;
    int        lat;
  } exp_t;

  exp_t       sb [$];
  logic [4:0] stim [STIM_LEN];
  int         n_checks = 0;
  int         n_fail   = 0;

  pbit_sample_stats #(.N_BITS(NB), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .settle        (settle),
    .window        (window),
    .p_bits        (p_bits),
    .busy          (busy),
    .done          (done),
    .results_valid (results_valid),
    .counts        (counts),
    .majority      (majority)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return {16'd0, counts[i*CW +: CW]};
  endfunction

  // Runs one measurement starting at a negedge; stim[j] is the value sampled at edge t+j.
  task automatic run(input string name, input int s, input int w, input int mid_start);
    exp_t e;
    exp_t got;
    int   seen;
    logic busy_ok;
    e.lat = s + w;
    e.maj = 5'd0;
    for (int i = 0; i < NB; i++) begin
      e.cnt[i] = 0;
      for (int j = s + 1; j <= s + w; j++)
        e.cnt[i] += int'(stim[j][i]);
      e.maj[i] = (2 * e.cnt[i] > w);
    end
    sb.push_back(e);
    settle = s[7:0];
    window = w[15:0];
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    seen    = -1;
    busy_ok = 1'b1;
    for (int c = 0; c <= s + w + 4; c++) begin
      if (done) begin
        seen = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (c == mid_start) begin
        start  = 1'b1;
        window = 16'd7;
      end else begin
        start = 1'b0;
      end
      p_bits = stim[c + 1];
      @(negedge clk);
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({name, "_latency"}, seen, got.lat);
    chk({name, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    if (seen >= 0) begin
      for (int i = 0; i < NB; i++)
        chk($sformatf("%s_count%0d", name, i), cnt_of(i), got.cnt[i]);
      chk({name, "_majority"}, {27'd0, majority}, {27'd0, got.maj});
      chk({name, "_valid_at_done"}, {31'd0, results_valid}, 32'd1);
      chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({name, "_done_falls"}, {31'd0, done}, 32'd0);
      chk({name, "_busy_falls"}, {31'd0, busy}, 32'd0);
      chk({name, "_valid_holds"}, {31'd0, results_valid}, 32'd1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    settle = 8'd0;
    window = 16'd0;
    p_bits = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_valid", {31'd0, results_valid}, 32'd0);
    chk("reset_counts", counts[31:0], 32'd0);
    chk("reset_majority", {27'd0, majority}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All ones, no settle.
    for (int j = 0; j < STIM_LEN; j++) stim[j] = 5'b11111;
    run("ones100", 0, 100, -1);

    // Alternating patterns, even and odd windows (back-to-back starts).
    for (int j = 1; j < STIM_LEN; j++) stim[j] = (j % 2 == 1) ? 5'b10101 : 5'b01010;
    run("toggle10", 0, 10, -1);
    run("toggle11", 0, 11, -1);
    chk("toggle11_maj_const", {27'd0, majority}, 32'h15);

    // Settle discards ones.
    for (int j = 1; j < STIM_LEN; j++) stim[j] = (j <= 20) ? 5'b11111 : 5'b00000;
    run("settle20", 20, 50, -1);

    // Empty windows.
    run("win0", 0, 0, -1);
    run("settle3_win0", 3, 0, -1);

    // Start pulse mid-ACCUM must not relatch window.
    for (int j = 1; j < STIM_LEN; j++) stim[j] = (j % 3 == 0) ? 5'b00110 : 5'b11001;
    run("midstart", 2, 40, 12);

    // Abort at sample 30 of 100, with a same-cycle start that must lose.
    for (int j = 0; j < STIM_LEN; j++) stim[j] = 5'b11111;
    p_bits = 5'b11111;
    settle = 8'd0;
    window = 16'd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_pre_count", cnt_of(0), 32'd30);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_valid", {31'd0, results_valid}, 32'd0);
    chk("abort_count_hold", cnt_of(2), 32'd30);
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      chk("abort_stays_idle", {31'd0, saw_done}, 32'd0);
    end

    // Asynchronous reset mid-SETTLE.
    settle = 8'd20;
    window = 16'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_counts", counts[31:0], 32'd0);
    chk("async_reset_valid", {31'd0, results_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int j = 1; j < STIM_LEN; j++) stim[j] = (j % 4 == 0) ? 5'b00000 : 5'b01110;
    run("after_reset", 1, 8, -1);

    // Biased stream resembling a clamped full adder (a=b=1, cin=0, S=0, Cout=1).
    for (int j = 1; j < STIM_LEN; j++) begin
      stim[j][0] = ($urandom_range(0, 99) < 92);
      stim[j][1] = ($urandom_range(0, 99) < 92);
      stim[j][2] = ($urandom_range(0, 99) < 8);
      stim[j][3] = ($urandom_range(0, 99) < 10);
      stim[j][4] = ($urandom_range(0, 99) < 90);
    end
    run("adder", 16, 10000, -1);
    chk("adder_maj_const", {27'd0, majority}, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
